// File: rtl/multiplier_iterative_rtl.sv
// multiplier_iterative_rtl: multi-cycle shift-add integer multiplier for the RV32M multiply group
module multiplier_iterative_rtl #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [1:0]       mode,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] result
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [1:0] MUL    = 2'b00;
   localparam logic [1:0] MULH   = 2'b01;
   localparam logic [1:0] MULHSU = 2'b10;
   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               high_q, high_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               a_signed, b_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] step_sum, product;
   logic               last;
   // Operand magnitudes so the datapath only ever does an unsigned shift-add;
   // the most-negative value maps onto itself, which is its correct unsigned magnitude
   always_comb begin
      a_signed = (mode == MULH) || (mode == MULHSU);
      b_signed = mode == MULH;
      a_neg    = a_signed && in0[WIDTH-1];
      b_neg    = b_signed && in1[WIDTH-1];
      a_mag    = a_neg ? -in0 : in0;
      b_mag    = b_neg ? -in1 : in1;
   end
   // One iteration: add the shifted multiplicand for each retired multiplier bit, then fix the sign
   always_comb begin
      step_sum = acc_q;
      for (int j = 0; j < BITS_PER_CYCLE; j++)
         step_sum = step_sum + (mplier_q[j] ? (mcand_q << j) : '0);
      product = neg_q ? -step_sum : step_sum;
      last    = cnt_q == CW'(N - 1);
   end
   // Next-state logic: IDLE latches operands, CALC iterates N times, DONE holds until consumed
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      high_d   = high_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (in_val) begin
            state_d  = CALC;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            neg_d    = a_neg ^ b_neg;
            high_d   = mode != MUL;
         end
         CALC: begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
               state_d  = DONE;
               result_d = high_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
            end
         end
         DONE: state_d = out_rdy ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // State registers; reset aborts any in-flight or held request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         high_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         high_q   <= high_d;
         result_q <= result_d;
      end
   end
   assign in_rdy  = state_q == IDLE;
   assign out_val = state_q == DONE;
   assign result  = result_q;
endmodule

// File: tb/tb_multiplier_iterative_rtl.sv
// tb_multiplier_iterative_rtl: vector table, handshake sequences and random checks over three configurations
module tb_multiplier_iterative_rtl;
   typedef struct {
      int          w;
      logic [1:0]  m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;
   logic clk = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_done = 0;
   vec_t tbl [$];
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   initial begin
      tbl.push_back('{32, 2'b00, 32'd3,         32'd5,         32'd15});
      tbl.push_back('{32, 2'b00, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF});
      tbl.push_back('{32, 2'b00, 32'h80000000,  32'd2,         32'h00000000});
      tbl.push_back('{32, 2'b00, 32'd100000,    32'd100000,    32'h540BE400});
      tbl.push_back('{32, 2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE});
      tbl.push_back('{32, 2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000});
      tbl.push_back('{32, 2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF});
      tbl.push_back('{32, 2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001});
      tbl.push_back('{32, 2'b01, 32'h80000000,  32'h80000000,  32'h40000000});
      tbl.push_back('{32, 2'b01, 32'hFFFFFFFE,  32'd2,         32'hFFFFFFFF});
      tbl.push_back('{32, 2'b00, 32'hFFFFFFFE,  32'd2,         32'hFFFFFFFC});
      tbl.push_back('{32, 2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h80000000});
      tbl.push_back('{8,  2'b01, 32'h80,        32'h80,        32'h40});
      tbl.push_back('{8,  2'b11, 32'hFF,        32'hFF,        32'hFE});
      tbl.push_back('{8,  2'b01, 32'hFF,        32'hFF,        32'h00});
      tbl.push_back('{8,  2'b10, 32'hFF,        32'hFF,        32'hFF});
      tbl.push_back('{8,  2'b00, 32'hFF,        32'hFF,        32'h01});
      tbl.push_back('{8,  2'b00, 32'h03,        32'h05,        32'h0F});
      tbl.push_back('{8,  2'b10, 32'h80,        32'hFF,        32'h80});
   end
   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int W = (g == 2) ? 8 : 32;
      localparam int B = (g == 0) ? 1 : ((g == 1) ? 4 : 2);
      localparam int N = W / B;
      logic         reset = 1'b0;
      logic         in_val = 1'b0;
      logic         out_rdy = 1'b0;
      logic         in_rdy, out_val;
      logic [1:0]   mode = 2'b00;
      logic [W-1:0] in0 = '0;
      logic [W-1:0] in1 = '0;
      logic [W-1:0] result;
      logic [W-1:0] exp_q [$];
      multiplier_iterative_rtl #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
         .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in0(in0), .in1(in1),
         .mode(mode), .out_val(out_val), .out_rdy(out_rdy), .result(result)
      );
      function automatic string nm(input string s);
         return $sformatf("cfg%0d(W=%0d,B=%0d) %s", g, W, B, s);
      endfunction
      function automatic logic [W-1:0] ref_mul(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
         logic [2*W-1:0] ea, eb, p;
         ea = ((m == 2'b01 || m == 2'b10) && a[W-1]) ? {{W{1'b1}}, a} : {{W{1'b0}}, a};
         eb = (m == 2'b01 && b[W-1]) ? {{W{1'b1}}, b} : {{W{1'b0}}, b};
         p  = ea * eb;
         return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
      endfunction
      // scoreboard: every output fire is checked against the oldest expected result
      always @(negedge clk)
         if (reset && out_val && out_rdy) begin
            if (exp_q.size() == 0) check(nm("unexpected output"), 64'(exp_q.size()), 64'd1);
            else check(nm("result"), 64'(result), 64'(exp_q.pop_front()));
         end
      task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input bit keep);
         int c;
         c = 0;
         while (!in_rdy && c < 100) begin
            @(negedge clk);
            c++;
         end
         check(nm("ready to accept"), 64'(in_rdy), 64'd1);
         mode = m;
         in0 = a;
         in1 = b;
         in_val = 1'b1;
         @(posedge clk);
         if (keep) exp_q.push_back(e);
         #1 in_val = 1'b0;
      endtask
      task automatic wait_out(input bit toggle);
         int c;
         c = 0;
         @(negedge clk);
         while (!out_val && c < N + 4) begin
            if (toggle) begin
               in0 = W'($urandom);
               in1 = W'($urandom);
               mode = 2'($urandom);
               in_val = 1'($urandom);
            end
            @(negedge clk);
            c++;
         end
         in_val = 1'b0;
         check(nm("latency"), 64'(c), 64'(N));
      endtask
      task automatic recv(input int hold);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check(nm("held result"), 64'(result), 64'(exp_q[0]));
            check(nm("held out_val"), 64'(out_val), 64'd1);
            check(nm("in_rdy while held"), 64'(in_rdy), 64'd0);
         end
         @(posedge clk);
         #1 out_rdy = 1'b1;
         @(posedge clk);
         #1 out_rdy = 1'b0;
      endtask
      initial begin
         logic [W-1:0] a, b;
         logic [1:0]   m;
         int           cyc;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check(nm("reset in_rdy"), 64'(in_rdy), 64'd1);
         check(nm("reset out_val"), 64'(out_val), 64'd0);
         check(nm("reset result"), 64'(result), 64'd0);
         @(posedge clk);
         #1 reset = 1'b1;
         for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].w == W) begin
               issue(tbl[i].m, W'(tbl[i].a), W'(tbl[i].b), W'(tbl[i].e), 1'b1);
               wait_out(1'b0);
               recv(0);
            end
         a = W'(32'h9ABCDEF1);
         b = W'(32'h87654321);
         issue(2'b01, a, b, ref_mul(2'b01, a, b), 1'b1);
         wait_out(1'b0);
         recv(5);
         a = W'(32'h12345678);
         b = W'(32'hF00DCAFE);
         issue(2'b10, a, b, ref_mul(2'b10, a, b), 1'b1);
         wait_out(1'b1);
         recv(0);
         issue(2'b00, W'(32'd11), W'(32'd13), W'(32'd143), 1'b1);
         wait_out(1'b0);
         mode = 2'b11;
         in0 = W'(32'hC3);
         in1 = W'(32'hA5);
         in_val = 1'b1;
         @(posedge clk);
         #1 out_rdy = 1'b1;
         check(nm("b2b in_rdy in DONE"), 64'(in_rdy), 64'd0);
         @(posedge clk);
         #1 out_rdy = 1'b0;
         check(nm("b2b idle after fire"), 64'(in_rdy), 64'd1);
         @(posedge clk);
         exp_q.push_back(ref_mul(2'b11, W'(32'hC3), W'(32'hA5)));
         #1 in_val = 1'b0;
         check(nm("b2b accepted next cycle"), 64'(in_rdy), 64'd0);
         wait_out(1'b0);
         recv(0);
         cyc = (N > 10) ? 10 : N / 2;
         issue(2'b11, W'(32'hDEADBEEF), W'(32'hFEEDF00D), '0, 1'b0);
         repeat (cyc - 1) @(posedge clk);
         #1 reset = 1'b0;
         #1;
         check(nm("abort out_val"), 64'(out_val), 64'd0);
         check(nm("abort in_rdy"), 64'(in_rdy), 64'd1);
         check(nm("abort result"), 64'(result), 64'd0);
         @(posedge clk);
         #1 reset = 1'b1;
         issue(2'b00, W'(32'd7), W'(32'd6), W'(32'd42), 1'b1);
         wait_out(1'b0);
         recv(0);
         for (int i = 0; i < 50; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            m = 2'($urandom);
            issue(m, a, b, ref_mul(m, a, b), 1'b1);
            wait_out(1'b0);
            recv($urandom_range(0, 2));
         end
         repeat (2) @(posedge clk);
         check(nm("scoreboard drained"), 64'(exp_q.size()), 64'd0);
         n_done++;
      end
   end
   initial begin
      int t;
      t = 0;
      while (n_done < 3 && t < 50000) begin
         @(posedge clk);
         t++;
      end
      if (n_done < 3) begin
         n_chk++;
         $display("FAIL timeout: configurations finished %0d expected 3", n_done);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/multiplier_iterative_rtl.md
Name: multiplier_iterative_rtl

Overview:
Parametrised multi-cycle integer multiplier, the successor to the single-cycle 32x32 combinational multiplier. It is used by the TinyRV1 datapath once the ISA grows to the full RV32M multiply group. It accepts operands over a val/rdy handshake and computes the full 2*WIDTH-bit product over several cycles, retiring BITS_PER_CYCLE multiplier bits per cycle. It returns either the low or the high WIDTH bits, with signed, unsigned or mixed operand interpretation, over a val/rdy output handshake.

Parameters:
- WIDTH, 32: operand and result width. Must be at least 4.
- BITS_PER_CYCLE, 1: multiplier bits retired per cycle. Must divide WIDTH. N = WIDTH/BITS_PER_CYCLE is the number of compute cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_val  in  1  request valid.
- in_rdy  out  1  unit can accept a request.
- in0  in  WIDTH  multiplicand (rs1).
- in1  in  WIDTH  multiplier (rs2).
- mode  in  2  operation: 00 MUL (low, any sign), 01 MULH (signed x signed, high), 10 MULHSU (signed in0 x unsigned in1, high), 11 MULHU (unsigned x unsigned, high).
- out_val  out  1  result valid.
- out_rdy  in  1  consumer can take the result.
- result  out  WIDTH  selected product half.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_rdy=1, out_val=0, result=0, all internal registers cleared. Deassertion takes effect at the next rising edge.
- Reset mid-operation aborts any in-flight or held result. No output is produced for that request.
- States and transitions:
  - IDLE: in_rdy=1, out_val=0. When in_val&&in_rdy at an edge, latch in0, in1 and mode, clear the counter, go to CALC.
  - CALC: in_rdy=0, out_val=0. Each cycle, add in1-partial-product(s) for BITS_PER_CYCLE bits and shift. The counter increments; after N CALC cycles go to DONE.
  - DONE: out_val=1, result stable. When out_val&&out_rdy at an edge, go to IDLE.
- in_rdy=0 in DONE. There is no accept in the same cycle as the output fire; the next request is accepted no earlier than the following cycle.
- Latency: a request accepted at edge k gives out_val=1 in the cycle after edge k+N (N=32 for defaults; 8 for WIDTH=32, BITS_PER_CYCLE=4).
- Throughput: one result per N+2 cycles minimum.
- Arithmetic: the product is the exact 2*WIDTH-bit value of the operands interpreted per mode.
  - Signed interpretation is two's complement.
  - Recommended implementation: take operand magnitudes, run an unsigned shift-add, and conditionally negate the 2*WIDTH product when the operand signs differ.
  - MUL returns product[WIDTH-1:0]. The high modes return product[2*WIDTH-1:WIDTH].
  - The most-negative operand (0x80000000) must be handled exactly; its magnitude needs WIDTH bits unsigned.
- Backpressure: while out_rdy=0 in DONE, result and out_val are held unchanged indefinitely.
- Inputs in0, in1, mode and in_val are ignored outside IDLE. Changing them during CALC must not affect the result.
- out_rdy is ignored outside DONE.
- No combinational path from in_val to in_rdy, or from out_rdy to out_val.

Test Plan:
- Basic MUL, mode=00: 3*5 -> 15; 0xFFFFFFFF*1 -> 0xFFFFFFFF; 0x80000000*2 -> 0; 100000*100000 -> 0x540BE400. Check out_val rises exactly N cycles after the accepting edge.
- High modes, in0=in1=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- Sign corners: MULH 0x80000000*0x80000000 -> 0x40000000; MULH 0xFFFFFFFE*2 -> 0xFFFFFFFF with MUL -> 0xFFFFFFFC; MULHSU 0x80000000*0xFFFFFFFF -> 0x80000000.
- Handshake:
  - out_rdy held 0 for 5 cycles after out_val rises -> result constant and in_rdy=0 throughout.
  - Operands toggled during CALC -> result unchanged.
  - Back-to-back requests -> second accepted only after the output fire.
- Reset: drive reset=0 mid-CALC (cycle 10) -> out_val, result and state clear immediately. After release, a new 7*6 request yields 42 with normal latency.
- Parametrisation and random checks:
  - Rerun the above with WIDTH=32, BITS_PER_CYCLE=4 (latency 8) and WIDTH=8, BITS_PER_CYCLE=2: 8-bit MULH 0x80*0x80 -> 0x40.
  - Add 50 random operand/mode pairs checked against a 2*WIDTH-bit reference product.
